// File: rtl/bidir_pkg.sv
// rtl/bidir_pkg.sv - shared types and constants for the bidirectional XOR FIFO
package bidir_pkg;

    typedef enum logic [1:0] {
        IN   = 2'd0,
        TURN = 2'd1,
        OUT  = 2'd2
    } dir_state_t;

    localparam logic [3:0] DEFAULT_MASK = 4'b1010;

endpackage

// File: rtl/bidir_fifo_core.sv
// rtl/bidir_fifo_core.sv - storage, pointers and occupancy count for the FIFO
module bidir_fifo_core #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push_ok;
    logic             pop_ok;

    // Guard here as well so the core can never overwrite or underflow.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rptr];

    // Storage is deliberately not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/bidir_xor_fifo.sv
// rtl/bidir_xor_fifo.sv - FIFO on a shared bus with turnaround FSM and XOR-masked output
module bidir_xor_fifo
    import bidir_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] MASK  = WIDTH'(DEFAULT_MASK)
) (
    input  logic                   clk,
    input  logic                   rst,
    inout  wire  [WIDTH-1:0]       data_io,
    input  logic                   io_select,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic                   drive_valid,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    dir_state_t       state;
    dir_state_t       state_next;
    logic [WIDTH-1:0] rdata;
    logic             push;
    logic             pop;

    // The bus is released the moment io_select rises, without waiting for the FSM.
    assign drive_valid = (state == OUT) && !io_select && !empty;
    assign push        = io_select && wr_en;
    assign pop         = drive_valid && rd_en;
    assign data_io     = drive_valid ? (rdata ^ MASK) : {WIDTH{1'bz}};

    bidir_fifo_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (data_io),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Direction state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IN;
        end else begin
            state <= state_next;
        end
    end

    // Next direction: TURN always lasts one cycle with the bus floating.
    always_comb begin
        state_next = state;
        case (state)
            IN:      if (!io_select) state_next = TURN;
            TURN:    state_next = io_select ? IN : OUT;
            OUT:     if (io_select) state_next = IN;
            default: state_next = IN;
        endcase
    end

endmodule

// File: tb/tb_bidir_xor_fifo.sv
// tb/tb_bidir_xor_fifo.sv - directed self-checking bench for bidir_xor_fifo
module tb_bidir_xor_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       io_select, wr_en, rd_en, tb_en;
    logic [3:0] tb_data;
    wire  [3:0] bus;
    logic       drive_valid, full, empty;
    logic [2:0] count;

    logic       io_select8, wr_en8, rd_en8, tb_en8;
    logic [7:0] tb_data8;
    wire  [7:0] bus8;
    logic       drive_valid8, full8, empty8;
    logic [2:0] count8;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] exp_drain [4] = '{4'hB, 4'h8, 4'h9, 4'hE};
    logic [3:0] exp_wrap  [6] = '{4'hA, 4'hB, 4'h8, 4'h9, 4'hE, 4'hF};

    always #5 clk = ~clk;

    assign bus  = tb_en  ? tb_data  : 4'bz;
    assign bus8 = tb_en8 ? tb_data8 : 8'bz;

    bidir_xor_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .data_io     (bus),
        .io_select   (io_select),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .drive_valid (drive_valid),
        .full        (full),
        .empty       (empty),
        .count       (count)
    );

    bidir_xor_fifo #(
        .WIDTH (8),
        .DEPTH (4),
        .MASK  (8'hFF)
    ) dut8 (
        .clk         (clk),
        .rst         (rst),
        .data_io     (bus8),
        .io_select   (io_select8),
        .wr_en       (wr_en8),
        .rd_en       (rd_en8),
        .drive_valid (drive_valid8),
        .full        (full8),
        .empty       (empty8),
        .count       (count8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_z(input string tag);
        check({tag, "_dv"}, 32'(drive_valid), 32'd0);
        check({tag, "_bus"}, 32'($countones(bus)), 32'd0);
    endtask

    task automatic check_drv(input string tag, input logic [3:0] v);
        check({tag, "_dv"}, 32'(drive_valid), 32'd1);
        check({tag, "_bus"}, 32'(bus), 32'(v));
    endtask

    task automatic push4(input logic [3:0] v);
        io_select = 1'b1;
        wr_en     = 1'b1;
        tb_en     = 1'b1;
        tb_data   = v;
        tick();
        wr_en     = 1'b0;
        tb_en     = 1'b0;
    endtask

    task automatic pop4();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic go_in();
        io_select = 1'b1;
        tick();
    endtask

    task automatic go_out();
        io_select = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        io_select = 1'b1; wr_en = 1'b0; rd_en = 1'b0; tb_en = 1'b0; tb_data = '0;
        io_select8 = 1'b1; wr_en8 = 1'b0; rd_en8 = 1'b0; tb_en8 = 1'b0; tb_data8 = '0;
        #2;
        check_z("rst");
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic push, turnaround, drain
        push4(4'h3);
        push4(4'h5);
        check("basic_count", 32'(count), 32'd2);
        io_select = 1'b0;
        tick();
        check_z("turn");
        tick();
        check_drv("basic0", 4'h9);
        pop4();
        check_drv("basic1", 4'hF);
        pop4();
        check_z("basic_empty");
        check("basic_empty_flag", 32'(empty), 32'd1);

        // Overfill: fifth push dropped
        go_in();
        for (int i = 1; i <= 4; i++) push4(4'(i));
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'd4);
        push4(4'h5);
        check("full_drop_count", 32'(count), 32'd4);
        go_out();
        for (int i = 0; i < 4; i++) begin
            check_drv("drain", exp_drain[i]);
            pop4();
        end
        check("drain_empty", 32'(empty), 32'd1);
        check_z("drain_z");

        // io_select rising mid-drive releases bus immediately
        go_in();
        push4(4'h6);
        push4(4'h7);
        go_out();
        check_drv("mid0", 4'hC);
        io_select = 1'b1;
        #1;
        check_z("mid_release");
        tick();
        io_select = 1'b0;
        #1;
        check_z("mid_in");
        tick();
        check_z("mid_turn");
        tick();
        check_drv("mid_reenter", 4'hC);
        pop4();
        check_drv("mid1", 4'hD);
        pop4();
        check("mid_empty", 32'(empty), 32'd1);

        // Wrap across direction changes
        for (int i = 0; i < 6; i++) begin
            go_in();
            push4(4'(i));
            go_out();
            check_drv("wrap", exp_wrap[i]);
            pop4();
        end
        check("wrap_count", 32'(count), 32'd0);
        check_z("wrap_z");

        // Asynchronous reset mid-drive
        go_in();
        push4(4'h3);
        go_out();
        check_drv("arst_pre", 4'h9);
        #2;
        rst = 1'b1;
        #1;
        check_z("arst");
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        rd_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        rd_en = 1'b0;
        check("arst_pop_ignored", 32'(count), 32'd0);
        check_z("arst_after");
        go_in();
        push4(4'h4);
        check("arst_push_count", 32'(count), 32'd1);
        go_out();
        check_drv("arst_push", 4'hE);
        pop4();
        check("arst_final_empty", 32'(empty), 32'd1);

        // Wide instance with all-ones mask
        io_select8 = 1'b1;
        wr_en8 = 1'b1;
        tb_en8 = 1'b1;
        tb_data8 = 8'h5A;
        tick();
        wr_en8 = 1'b0;
        tb_en8 = 1'b0;
        io_select8 = 1'b0;
        tick();
        tick();
        check("w8_dv", 32'(drive_valid8), 32'd1);
        check("w8_bus", 32'(bus8), 32'hA5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bidir_xor_fifo.md
BIDIR_XOR_FIFO -- requirements
Module: bidir_xor_fifo

Interface
REQ-001 Parameter WIDTH, default 4: bus and entry width in bits, at least 1.
REQ-002 Parameter DEPTH, default 4: FIFO entries, a power of two, at least 2.
REQ-003 Parameter MASK, default 4'b1010 sized to WIDTH: XOR mask applied to outgoing data.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset, asynchronous, active-high.
REQ-006 data_io  inout  WIDTH: shared bidirectional bus.
REQ-007 io_select  input  1: 1 = external agent drives the bus; 0 = block may drive it.
REQ-008 wr_en  input  1: push request, qualified by io_select=1.
REQ-009 rd_en  input  1: pop request, qualified by drive_valid=1.
REQ-010 drive_valid  output  1: block is driving valid data on data_io this cycle.
REQ-011 full  output  1: count equals DEPTH.
REQ-012 empty  output  1: count equals 0.
REQ-013 count  output  $clog2(DEPTH)+1: number of stored entries.

Function
REQ-014 Push: at a rising edge with io_select=1, wr_en=1 and full=0, data_io shall be stored at the write pointer; the pointer advances modulo DEPTH; count increments.
REQ-015 A push with full=1 shall be ignored: no state change, no overwrite.
REQ-016 Direction FSM has states IN, TURN and OUT; reset state is IN.
REQ-017 Transitions: IN->TURN when io_select=0 at a clock edge; TURN->OUT if io_select=0, else TURN->IN; OUT->IN when io_select=1; otherwise the state holds.
REQ-018 TURN gives exactly one bus-turnaround cycle with data_io at high impedance.
REQ-019 drive_valid = (state==OUT) && io_select==0 && empty==0, combinationally; when io_select rises, the bus shall be released in the same cycle, before the FSM updates.
REQ-020 While drive_valid=1, data_io = mem[read pointer] XOR MASK; otherwise data_io is all-Z.
REQ-021 Pop: at a rising edge with drive_valid=1 and rd_en=1, the read pointer advances modulo DEPTH and count decrements; the next entry appears on data_io the following cycle (first-word fall-through).
REQ-022 rd_en with drive_valid=0 shall be ignored.
REQ-023 Push and pop cannot occur in the same cycle, because io_select makes them exclusive; count changes by at most 1 per cycle.
REQ-024 Pointers wrap from DEPTH-1 to 0 with no gap or bubble.
REQ-025 While empty in OUT, the bus stays Z; once draining empties the FIFO, the bus goes Z in the cycle after the last pop.
REQ-026 full and empty are derived from count and are never both 1.

Reset
REQ-027 When rst is asserted: state=IN, both pointers=0, count=0, empty=1, full=0, drive_valid=0, data_io=Z, all immediately without waiting for clk.
REQ-028 Reset mid-drive shall release the bus asynchronously; storage contents are not reset and are unreachable after reset.
REQ-029 Deassertion of rst takes effect at the next rising edge of clk; the first push may occur on that edge.

Structure
REQ-030 Package bidir_pkg shall hold the direction-state enum (IN, TURN, OUT) and the default MASK constant.
REQ-031 Storage, pointers and count shall live in sub-module bidir_fifo_core; the top level holds the FSM, the tristate driver and the XOR.

Verification
REQ-032 Reset then push 0x3, 0x5 (io_select=1) then io_select=0 -> bus Z in TURN; then 0x9 with drive_valid=1; pop -> 0xF; pop -> bus Z, empty=1.
REQ-033 Push 5 values 0x1..0x5 at DEPTH=4 -> full=1 after the 4th; the 5th is dropped; the drain yields 0xB, 0x8, 0x9, 0xE.
REQ-034 Drive phase with io_select raised mid-drive -> drive_valid=0 and bus Z in the same cycle; re-entry requires a new TURN cycle.
REQ-035 Wrap test: 6 push/pop pairs of 0x0..0x5 interleaved across direction changes -> output order 0xA, 0xB, 0x8, 0x9, 0xE, 0xF and count returns to 0.
REQ-036 rst asserted asynchronously while driving 0x9 -> bus Z and count=0 before the next clk edge; pop ignored afterwards.
REQ-037 WIDTH=8, MASK=0xFF: push 0x5A -> driven value 0xA5.
